bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 29 ++
 rtl/bus_wdog.sv | 46 ++++
 rtl/bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter slice.
//   - ChipEnable/WriteEnable style control constants
//   - bus data width, byte-select width and default timeout
//   - FSM state encoding and last-grant flag encoding
package bus_arbiter_pkg;

  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam int BUS_W       = 32;
  localparam int SEL_W       = 4;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEM_XFER = 3'd1,
    ST_IF_XFER  = 3'd2,
    ST_MEM_DONE = 3'd3,
    ST_IF_DONE  = 3'd4
  } arb_state_e;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

endpackage

// File: rtl/bus_wdog.sv
// Bus transfer watchdog.
//   clk       : clock
//   rst       : asynchronous active-low reset
//   clear_i   : hold the count at zero (asserted while no transfer is running)
//   enable_i  : count one more cycle without acknowledge
//   expired_o : this enabled cycle is the TIMEOUT-th one without acknowledge
module bus_wdog
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TOP  = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // The count equals the number of un-acked cycles already seen, so the
  // cycle that finds LAST in the register is the TIMEOUT-th one.
  assign expired_o = enable_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q < TOP)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Single-port bus arbiter between instruction fetch (IF) and MEM stage.
//   if_*      : fetch read request, fetched word, fetch stall
//   mem_*     : load/store request, load data, MEM stall
//   bus_*     : shared bus master outputs, slave ack/read data
//   flush_i   : pipeline flush; blocks a new grant while in IDLE only
//   bus_err_o : one-cycle pulse when a transfer times out
//   dbg_state_o : current FSM state (arb_state_e encoding)
// Handshake: a transfer is offered by holding bus_req_o high with constant
// we/sel/addr/wdata; it completes on the first rising edge where bus_ack_i
// is high, and bus_rdata_i is taken on that same edge.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_ce_i,
  input  logic [BUS_W-1:0] if_addr_i,
  output logic [BUS_W-1:0] if_data_o,
  output logic             stallreq_if_o,
  input  logic             mem_ce_i,
  input  logic             mem_we_i,
  input  logic [SEL_W-1:0] mem_sel_i,
  input  logic [BUS_W-1:0] mem_addr_i,
  input  logic [BUS_W-1:0] mem_data_i,
  output logic [BUS_W-1:0] mem_data_o,
  output logic             stallreq_mem_o,
  output logic             bus_req_o,
  output logic             bus_we_o,
  output logic [SEL_W-1:0] bus_sel_o,
  output logic [BUS_W-1:0] bus_addr_o,
  output logic [BUS_W-1:0] bus_wdata_o,
  input  logic             bus_ack_i,
  input  logic [BUS_W-1:0] bus_rdata_i,
  input  logic             flush_i,
  output logic             bus_err_o,
  output logic [2:0]       dbg_state_o
);

  arb_state_e       state_q, state_d;
  grant_e           last_q, last_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [BUS_W-1:0] addr_q, addr_d;
  logic [BUS_W-1:0] wdata_q, wdata_d;
  logic [BUS_W-1:0] if_data_q, if_data_d;
  logic [BUS_W-1:0] mem_data_q, mem_data_d;
  logic             err_q, err_d;
  logic             in_xfer, expired;

  assign in_xfer = (state_q == ST_MEM_XFER) || (state_q == ST_IF_XFER);

  bus_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q == ST_IDLE),
    .enable_i  (in_xfer && !bus_ack_i),
    .expired_o (expired)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    req_d      = req_q;
    we_d       = we_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_data_d  = if_data_q;
    mem_data_d = mem_data_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush_i) begin
          // MEM wins unless it was served last and a fetch is waiting.
          if ((mem_ce_i == ChipEnable) &&
              !((if_ce_i == ChipEnable) && (last_q == GRANT_MEM))) begin
            state_d = ST_MEM_XFER;
            last_d  = GRANT_MEM;
            req_d   = ChipEnable;
            we_d    = mem_we_i;
            sel_d   = mem_sel_i;
            addr_d  = mem_addr_i;
            wdata_d = mem_data_i;
          end else if (if_ce_i == ChipEnable) begin
            state_d = ST_IF_XFER;
            last_d  = GRANT_IF;
            req_d   = ChipEnable;
            we_d    = WriteDisable;
            sel_d   = '1;
            addr_d  = if_addr_i;
            wdata_d = '0;
          end
        end
      end
      ST_MEM_XFER: begin
        // Ack has precedence over a timeout landing on the same cycle.
        if (bus_ack_i) begin
          mem_data_d = bus_rdata_i;
          req_d      = ChipDisable;
          state_d    = ST_MEM_DONE;
        end else if (expired) begin
          mem_data_d = '0;
          req_d      = ChipDisable;
          err_d      = 1'b1;
          state_d    = ST_MEM_DONE;
        end
      end
      ST_IF_XFER: begin
        if (bus_ack_i) begin
          if_data_d = bus_rdata_i;
          req_d     = ChipDisable;
          state_d   = ST_IF_DONE;
        end else if (expired) begin
          if_data_d = '0;
          req_d     = ChipDisable;
          err_d     = 1'b1;
          state_d   = ST_IF_DONE;
        end
      end
      ST_MEM_DONE: state_d = ST_IDLE;
      ST_IF_DONE:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      last_q     <= GRANT_IF;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      mem_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      req_q      <= req_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
      err_q      <= err_d;
    end
  end

  assign bus_req_o      = req_q;
  assign bus_we_o       = we_q;
  assign bus_sel_o      = sel_q;
  assign bus_addr_o     = addr_q;
  assign bus_wdata_o    = wdata_q;
  assign if_data_o      = if_data_q;
  assign mem_data_o     = mem_data_q;
  assign bus_err_o      = err_q;
  assign dbg_state_o    = state_q;
  assign stallreq_mem_o = mem_ce_i && (state_q != ST_MEM_DONE);
  assign stallreq_if_o  = if_ce_i && (state_q != ST_IF_DONE);

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam logic [31:0] S_IDLE = 32'd0, S_MEMX = 32'd1, S_IFX = 32'd2,
                          S_MEMD = 32'd3, S_IFD = 32'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_ce = 1'b0, mem_ce = 1'b0, mem_we = 1'b0, bus_ack = 1'b0, flush = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, bus_rdata = '0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] if_data, mem_data, bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic [2:0]  dbg_state;
  logic        stall_if, stall_mem, bus_req, bus_we, bus_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  bus_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce), .if_addr_i(if_addr), .if_data_o(if_data), .stallreq_if_o(stall_if),
    .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
    .mem_data_i(mem_wdata), .mem_data_o(mem_data), .stallreq_mem_o(stall_mem),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_sel_o(bus_sel), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata),
    .flush_i(flush), .bus_err_o(bus_err), .dbg_state_o(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge,
  // checks happen 1 time unit after that
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [11:0] exp_req_v, exp_smem_v, exp_sif_v;
    logic [31:0] e;

    // ---------------- reset ----------------
    #1 rst = 1'b0;
    #1;
    check("rst_req_async", {31'd0, bus_req}, 32'd0);
    check("rst_state_async", {29'd0, dbg_state}, S_IDLE);
    tick(); tick();
    check("rst_req", {31'd0, bus_req}, 32'd0);
    check("rst_we", {31'd0, bus_we}, 32'd0);
    check("rst_sel", {28'd0, bus_sel}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    check("rst_wdata", bus_wdata, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_mem_data", mem_data, 32'd0);
    check("rst_err", {31'd0, bus_err}, 32'd0);
    rst = 1'b1;
    tick();

    // ------- both requesters, ack always high: MEM, IF, MEM, IF -------
    exp_req_v  = 12'h492;   // req high at cycles 1,4,7,10
    exp_smem_v = 12'hEFB;   // MEM stall low at cycles 2,8
    exp_sif_v  = 12'h7DF;   // IF stall low at cycles 5,11
    exp_q.push_back(32'h300); exp_q.push_back(32'h400);
    exp_q.push_back(32'h300); exp_q.push_back(32'h400);
    mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h300;
    if_ce = 1'b1; if_addr = 32'h400; bus_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus_rdata = 32'hA000_0000 + 32'(i);
      settle();
      check($sformatf("alt_req_c%0d", i), {31'd0, bus_req}, {31'd0, exp_req_v[i]});
      check($sformatf("alt_smem_c%0d", i), {31'd0, stall_mem}, {31'd0, exp_smem_v[i]});
      check($sformatf("alt_sif_c%0d", i), {31'd0, stall_if}, {31'd0, exp_sif_v[i]});
      if (bus_req && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("alt_grant_c%0d", i), bus_addr, e);
      end
      if (i == 8)  check("alt_mem_data", mem_data, 32'hA000_0007);
      if (i == 11) check("alt_if_data", if_data, 32'hA000_000A);
      tick();
    end
    check("alt_grants_left", 32'(exp_q.size()), 32'd0);
    mem_ce = 1'b0; if_ce = 1'b0; bus_ack = 1'b0;
    tick();

    // ------- single MEM read, ack on first XFER cycle -------
    mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
    settle();
    check("rd_c0_stall", {31'd0, stall_mem}, 32'd1);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    settle();
    check("rd_c1_req", {31'd0, bus_req}, 32'd1);
    check("rd_c1_addr", bus_addr, 32'h100);
    check("rd_c1_we", {31'd0, bus_we}, 32'd0);
    tick();
    bus_ack = 1'b0;
    settle();
    check("rd_c2_req", {31'd0, bus_req}, 32'd0);
    check("rd_c2_data", mem_data, 32'hDEAD_BEEF);
    check("rd_c2_stall", {31'd0, stall_mem}, 32'd0);
    check("rd_c2_state", {29'd0, dbg_state}, S_MEMD);
    mem_ce = 1'b0;
    tick();
    check("rd_c3_state", {29'd0, dbg_state}, S_IDLE);
    check("rd_c3_hold", mem_data, 32'hDEAD_BEEF);
    tick();

    // ------- MEM write, ack delayed 5 cycles -------
    mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011;
    mem_addr = 32'h200; mem_wdata = 32'h1234_5678;
    tick();
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) begin mem_addr = 32'h0BAD_0000; mem_wdata = 32'h0; mem_we = 1'b0; end
      if (k == 6) begin bus_ack = 1'b1; bus_rdata = 32'h0000_5A5A; end
      settle();
      check($sformatf("sw_req_c%0d", k), {31'd0, bus_req}, 32'd1);
      check($sformatf("sw_we_c%0d", k), {31'd0, bus_we}, 32'd1);
      check($sformatf("sw_sel_c%0d", k), {28'd0, bus_sel}, 32'h3);
      check($sformatf("sw_addr_c%0d", k), bus_addr, 32'h200);
      check($sformatf("sw_wdata_c%0d", k), bus_wdata, 32'h1234_5678);
      tick();
    end
    bus_ack = 1'b0; mem_ce = 1'b0;
    settle();
    check("sw_done_req", {31'd0, bus_req}, 32'd0);
    check("sw_done_state", {29'd0, dbg_state}, S_MEMD);
    check("sw_done_err", {31'd0, bus_err}, 32'd0);
    tick();
    check("sw_idle", {29'd0, dbg_state}, S_IDLE);
    tick();

    // ------- IF fetch with no ack: timeout after 8 cycles -------
    if_ce = 1'b1; if_addr = 32'h40;
    tick();
    for (int k = 1; k <= 8; k++) begin
      settle();
      check($sformatf("to_req_c%0d", k), {31'd0, bus_req}, 32'd1);
      check($sformatf("to_err_c%0d", k), {31'd0, bus_err}, 32'd0);
      tick();
    end
    if_ce = 1'b0;
    settle();
    check("to_req_drop", {31'd0, bus_req}, 32'd0);
    check("to_err_pulse", {31'd0, bus_err}, 32'd1);
    check("to_if_data", if_data, 32'd0);
    check("to_state", {29'd0, dbg_state}, S_IFD);
    check("to_mem_keep", mem_data, 32'h0000_5A5A);
    tick();
    check("to_err_end", {31'd0, bus_err}, 32'd0);
    check("to_idle", {29'd0, dbg_state}, S_IDLE);

    // ------- ack outside a transfer is ignored -------
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    check("ign_state", {29'd0, dbg_state}, S_IDLE);
    check("ign_req", {31'd0, bus_req}, 32'd0);
    check("ign_mem", mem_data, 32'h0000_5A5A);
    check("ign_if", if_data, 32'd0);
    bus_ack = 1'b0;

    // ------- flush held in IDLE, then flush pulse during XFER -------
    flush = 1'b1; mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h500;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("fl_idle_req_%0d", k), {31'd0, bus_req}, 32'd0);
      check($sformatf("fl_idle_st_%0d", k), {29'd0, dbg_state}, S_IDLE);
    end
    flush = 1'b0;
    tick();
    check("fl_xfer_req", {31'd0, bus_req}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0F0F_0F0F;
    settle();
    check("fl_still_xfer", {29'd0, dbg_state}, S_MEMX);
    tick();
    bus_ack = 1'b0; mem_ce = 1'b0;
    settle();
    check("fl_done", {29'd0, dbg_state}, S_MEMD);
    check("fl_data", mem_data, 32'h0F0F_0F0F);
    tick();

    // ------- ack on the TIMEOUT-th cycle is a normal completion -------
    if_ce = 1'b1; if_addr = 32'h80;
    tick();
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) begin bus_ack = 1'b1; bus_rdata = 32'h55AA_55AA; end
      tick();
    end
    bus_ack = 1'b0; if_ce = 1'b0;
    settle();
    check("edge_err", {31'd0, bus_err}, 32'd0);
    check("edge_data", if_data, 32'h55AA_55AA);
    check("edge_state", {29'd0, dbg_state}, S_IFD);
    tick();

    // ------- reset mid-transfer -------
    mem_ce = 1'b1; mem_addr = 32'h600;
    tick();
    check("mr_req_before", {31'd0, bus_req}, 32'd1);
    if_ce = 1'b1;
    rst = 1'b0;
    #1;
    check("mr_req_async", {31'd0, bus_req}, 32'd0);
    check("mr_state_async", {29'd0, dbg_state}, S_IDLE);
    check("mr_mem_data", mem_data, 32'd0);
    tick();
    rst = 1'b1;
    settle();
    check("mr_idle_after", {29'd0, dbg_state}, S_IDLE);
    tick();
    check("mr_first_grant", {29'd0, dbg_state}, S_MEMX);
    check("mr_first_addr", bus_addr, 32'h600);
    mem_ce = 1'b0; if_ce = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
